// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct
// constants, datapath select encodings and the decoded instruction class.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDcd,
    StExe,
    StAluWb,
    StMa,
    StMrd,
    StMemWb,
    StMst,
    StBr,
    StJmp
  } state_e;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FunctAddu = 6'b100001;
  localparam logic [5:0] FunctSubu = 6'b100011;
  localparam logic [5:0] FunctJr   = 6'b001000;

  // Next-PC select
  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;
  localparam logic [1:0] NpcReg    = 2'b11;

  // Write register select
  localparam logic [1:0] RegdstRt = 2'b00;
  localparam logic [1:0] RegdstRd = 2'b01;
  localparam logic [1:0] RegdstRa = 2'b10;

  // Write data select
  localparam logic [1:0] WdselAlu = 2'b00;
  localparam logic [1:0] WdselMem = 2'b01;
  localparam logic [1:0] WdselPc4 = 2'b10;

  // Immediate extension
  localparam logic [1:0] ExtZero  = 2'b00;
  localparam logic [1:0] ExtSign  = 2'b01;
  localparam logic [1:0] ExtUpper = 2'b10;

  // ALU operation
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluOr  = 2'b10;

  // Instruction class, exactly one bit set. jump = j, link = jal, jreg = jr.
  typedef struct packed {
    logic rtype_alu;
    logic ialu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic jreg;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: maps op/funct to a one-hot instruction class plus the
// two sub-operation bits the controller needs inside a class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic       alu_sub_o,   // R-type ALU op is subu
  output logic       imm_upper_o  // I-type ALU op is lui
);

  // Combinational class decode; anything unrecognised lands in illegal.
  always_comb begin
    cls_o       = '0;
    alu_sub_o   = 1'b0;
    imm_upper_o = 1'b0;
    unique case (op_i)
      OpRtype: begin
        unique case (funct_i)
          FunctAddu: cls_o.rtype_alu = 1'b1;
          FunctSubu: begin
            cls_o.rtype_alu = 1'b1;
            alu_sub_o       = 1'b1;
          end
          FunctJr:   cls_o.jreg = 1'b1;
          default:   cls_o.illegal = 1'b1;
        endcase
      end
      OpOri:   cls_o.ialu = 1'b1;
      OpLui: begin
        cls_o.ialu  = 1'b1;
        imm_upper_o = 1'b1;
      end
      OpLw:    cls_o.load = 1'b1;
      OpSw:    cls_o.store = 1'b1;
      OpBeq:   cls_o.branch = 1'b1;
      OpJ:     cls_o.jump = 1'b1;
      OpJal:   cls_o.link = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-subset controller: state register plus next-state and
// output logic. Outputs are Moore except pcwr in BR, which follows zero.
module multi_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       irwr,
  output logic       pcwr,
  output logic [1:0] npcop,
  output logic       regwr,
  output logic [1:0] regdst,
  output logic [1:0] wdsel,
  output logic       bsel,
  output logic [1:0] extop,
  output logic [1:0] aluop,
  output logic       dmwr
);

  state_e  state_q, state_d;
  iclass_t cls;
  logic    alu_sub;
  logic    imm_upper;

  mc_decode u_decode (
    .op_i       (op),
    .funct_i    (funct),
    .cls_o      (cls),
    .alu_sub_o  (alu_sub),
    .imm_upper_o(imm_upper)
  );

  // State register; synchronous reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_d = state_q;
    irwr    = 1'b0;
    pcwr    = 1'b0;
    npcop   = NpcPc4;
    regwr   = 1'b0;
    regdst  = RegdstRt;
    wdsel   = WdselAlu;
    bsel    = 1'b0;
    extop   = ExtZero;
    aluop   = AluAdd;
    dmwr    = 1'b0;

    unique case (state_q)
      StFetch: begin
        irwr    = 1'b1;
        pcwr    = 1'b1;
        npcop   = NpcPc4;
        state_d = StDcd;
      end
      StDcd: begin
        if (cls.rtype_alu || cls.ialu) begin
          state_d = StExe;
        end else if (cls.load || cls.store) begin
          state_d = StMa;
        end else if (cls.branch) begin
          state_d = StBr;
        end else if (cls.jump || cls.link || cls.jreg) begin
          state_d = StJmp;
        end else begin
          state_d = StFetch;
        end
      end
      StExe: begin
        if (cls.rtype_alu) begin
          bsel  = 1'b0;
          aluop = alu_sub ? AluSub : AluAdd;
        end else begin
          bsel  = 1'b1;
          extop = imm_upper ? ExtUpper : ExtZero;
          aluop = AluOr;
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        regwr   = 1'b1;
        wdsel   = WdselAlu;
        regdst  = cls.rtype_alu ? RegdstRd : RegdstRt;
        state_d = StFetch;
      end
      StMa: begin
        bsel    = 1'b1;
        extop   = ExtSign;
        aluop   = AluAdd;
        state_d = cls.load ? StMrd : StMst;
      end
      StMrd: begin
        state_d = StMemWb;
      end
      StMemWb: begin
        regwr   = 1'b1;
        wdsel   = WdselMem;
        regdst  = RegdstRt;
        state_d = StFetch;
      end
      StMst: begin
        dmwr    = 1'b1;
        state_d = StFetch;
      end
      StBr: begin
        aluop   = AluSub;
        npcop   = NpcBranch;
        pcwr    = zero;
        state_d = StFetch;
      end
      StJmp: begin
        pcwr  = 1'b1;
        npcop = cls.jreg ? NpcReg : NpcJump;
        if (cls.link) begin
          regwr  = 1'b1;
          regdst = RegdstRa;
          wdsel  = WdselPc4;
        end
        state_d = StFetch;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset silences every enable and select in the same cycle.
    if (rst) begin
      irwr   = 1'b0;
      pcwr   = 1'b0;
      npcop  = 2'b00;
      regwr  = 1'b0;
      regdst = 2'b00;
      wdsel  = 2'b00;
      bsel   = 1'b0;
      extop  = 2'b00;
      aluop  = 2'b00;
      dmwr   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_ctrl.sv
// Bench for multi_ctrl: per-cycle expected output vectors are queued when an
// instruction is issued and compared by a negedge monitor as cycles elapse.
module tb_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       irwr, pcwr, regwr, bsel, dmwr;
  logic [1:0] npcop, regdst, wdsel, extop, aluop;

  multi_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .funct (funct),
    .zero  (zero),
    .irwr  (irwr),
    .pcwr  (pcwr),
    .npcop (npcop),
    .regwr (regwr),
    .regdst(regdst),
    .wdsel (wdsel),
    .bsel  (bsel),
    .extop (extop),
    .aluop (aluop),
    .dmwr  (dmwr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int irwr_cnt = 0;

  // {irwr, pcwr, npcop, regwr, regdst, wdsel, bsel, extop, aluop, dmwr}
  logic [14:0] obs;
  assign obs = {irwr, pcwr, npcop, regwr, regdst, wdsel, bsel, extop, aluop, dmwr};

  logic [14:0] exp_q[$];
  string       name_q[$];
  logic [14:0] mon_exp;
  string       mon_nm;

  function automatic logic [14:0] ev(input logic ir, input logic pc, input logic [1:0] npc,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] wd,
                                     input logic bs, input logic [1:0] ex, input logic [1:0] al,
                                     input logic dw);
    return {ir, pc, npc, rw, rd, wd, bs, ex, al, dw};
  endfunction

  // Scoreboard consumer plus per-cycle enable exclusivity.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((irwr & regwr) | (irwr & dmwr) | (regwr & dmwr)) begin
        failures++;
        $display("FAIL en_exclusive irwr=%0b regwr=%0b dmwr=%0b required at most one high",
                 irwr, regwr, dmwr);
      end
      if (irwr) irwr_cnt++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        checks++;
        if (obs !== mon_exp) begin
          failures++;
          $display("FAIL %s got=%h exp=%h (irwr pcwr npc regwr regdst wdsel bsel ext alu dmwr)",
                   mon_nm, obs, mon_exp);
        end
      end
    end
  end

  // Queue the full per-cycle expectation for one instruction.
  task automatic push_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                            input logic z, output int n);
    exp_q.push_back(ev(1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
    name_q.push_back({nm, ".fetch"});
    exp_q.push_back('0);
    name_q.push_back({nm, ".dcd"});
    n = 2;
    if (o == 6'b000000 && (f == 6'b100001 || f == 6'b100011)) begin
      exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00,
                         (f == 6'b100011) ? 2'b01 : 2'b00, 0));
      name_q.push_back({nm, ".exe"});
      exp_q.push_back(ev(0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0));
      name_q.push_back({nm, ".alu_wb"});
      n = 4;
    end else if (o == 6'b000000 && f == 6'b001000) begin
      exp_q.push_back(ev(0, 1, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
      name_q.push_back({nm, ".jmp"});
      n = 3;
    end else if (o == 6'b001101 || o == 6'b001111) begin
      exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 2'b00, 1,
                         (o == 6'b001111) ? 2'b10 : 2'b00, 2'b10, 0));
      name_q.push_back({nm, ".exe"});
      exp_q.push_back(ev(0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
      name_q.push_back({nm, ".alu_wb"});
      n = 4;
    end else if (o == 6'b100011) begin
      exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 0));
      name_q.push_back({nm, ".ma"});
      exp_q.push_back('0);
      name_q.push_back({nm, ".mrd"});
      exp_q.push_back(ev(0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0));
      name_q.push_back({nm, ".mem_wb"});
      n = 5;
    end else if (o == 6'b101011) begin
      exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 0));
      name_q.push_back({nm, ".ma"});
      exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1));
      name_q.push_back({nm, ".mst"});
      n = 4;
    end else if (o == 6'b000100) begin
      exp_q.push_back(ev(0, z, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0));
      name_q.push_back({nm, ".br"});
      n = 3;
    end else if (o == 6'b000010) begin
      exp_q.push_back(ev(0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
      name_q.push_back({nm, ".jmp"});
      n = 3;
    end else if (o == 6'b000011) begin
      exp_q.push_back(ev(0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 0));
      name_q.push_back({nm, ".jmp"});
      n = 3;
    end
  endtask

  // Called at #1 after a rising edge with the DUT in FETCH.
  task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z);
    int n;
    op    = o;
    funct = f;
    zero  = z;
    push_instr(nm, o, f, z, n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) begin
      op    = 6'($urandom);
      funct = 6'($urandom);
      zero  = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== 15'h0) begin
        failures++;
        $display("FAIL reset_outputs got=%h exp=%h", obs, 15'h0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_addu_lw();
    int c0;
    c0 = irwr_cnt;
    issue("addu", 6'b000000, 6'b100001, 1'b0);
    issue("lw", 6'b100011, 6'b010101, 1'b0);
    checks++;
    if (irwr_cnt - c0 != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL addu_lw_fetches got=%0d pending=%0d exp=2 pending=0",
               irwr_cnt - c0, exp_q.size());
    end
  endtask

  task automatic test_alu_ops();
    issue("subu", 6'b000000, 6'b100011, 1'b1);
    issue("ori", 6'b001101, 6'b111111, 1'b0);
    issue("lui", 6'b001111, 6'b000000, 1'b1);
    issue("sw", 6'b101011, 6'b000001, 1'b0);
    issue("jr", 6'b000000, 6'b001000, 1'b0);
    issue("j", 6'b000010, 6'b100001, 1'b1);
  endtask

  task automatic test_beq();
    issue("beq_taken", 6'b000100, 6'b000000, 1'b1);
    issue("beq_not_taken", 6'b000100, 6'b000000, 1'b0);
  endtask

  task automatic test_jal();
    issue("jal", 6'b000011, 6'b001000, 1'b0);
  endtask

  task automatic test_illegal();
    int c0;
    c0 = irwr_cnt;
    issue("illegal_op", 6'b111111, 6'b100001, 1'b1);
    issue("illegal_funct", 6'b000000, 6'b101010, 1'b1);
    checks++;
    if (irwr_cnt - c0 != 2) begin
      failures++;
      $display("FAIL illegal_fetches got=%0d exp=2", irwr_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_mrd();
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    exp_q.push_back(ev(1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
    name_q.push_back("lw_abort.fetch");
    exp_q.push_back('0);
    name_q.push_back("lw_abort.dcd");
    exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 0));
    name_q.push_back("lw_abort.ma");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    // Now in MRD: assert reset for two edges.
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs !== 15'h0) begin
        failures++;
        $display("FAIL reset_mid_mrd got=%h exp=%h", obs, 15'h0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    op  = 6'b111111;
    @(negedge clk);
    checks++;
    if (irwr !== 1'b1 || pcwr !== 1'b1 || regwr !== 1'b0 || dmwr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_fetch irwr=%0b pcwr=%0b regwr=%0b dmwr=%0b exp 1 1 0 0",
               irwr, pcwr, regwr, dmwr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (obs !== 15'h0) begin
      failures++;
      $display("FAIL post_reset_dcd got=%h exp=%h", obs, 15'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_stream();
    logic [5:0] ops[10];
    logic [5:0] fns[10];
    int c0, k;
    ops = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
            6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    fns = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    c0 = irwr_cnt;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(9));
      issue("rand", ops[k], (ops[k] == 6'b000000) ? fns[k] : 6'($urandom),
            1'($urandom));
    end
    checks++;
    if (irwr_cnt - c0 != 40) begin
      failures++;
      $display("FAIL rand_irwr_pulses got=%0d exp=40", irwr_cnt - c0);
    end
  endtask

  task automatic test_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    op    = '0;
    funct = '0;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_addu_lw();
    test_alu_ops();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_mrd();
    test_random_stream();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 op  in  6  instruction bits [31:26], taken from the instruction register output.
REQ-006 funct  in  6  instruction bits [5:0].
REQ-007 zero  in  1  ALU equality flag.
REQ-008 irwr  out  1  instruction register load enable.
REQ-009 pcwr  out  1  PC write enable.
REQ-010 npcop  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump target, 11 register (jr).
REQ-011 regwr  out  1  register file write enable.
REQ-012 regdst  out  2  write register select: 00 rt, 01 rd, 10 $31.
REQ-013 wdsel  out  2  write data select: 00 ALU, 01 data memory, 10 PC+4.
REQ-014 bsel  out  1  ALU B operand: 0 register, 1 extended immediate.
REQ-015 extop  out  2  immediate extension: 00 zero, 01 sign, 10 shift to upper half (lui).
REQ-016 aluop  out  2  ALU operation: 00 add, 01 sub, 10 or.
REQ-017 dmwr  out  1  data memory write enable.

Function
REQ-018 Supported instructions: addu (R, funct 100001), subu (R, funct 100011), jr (R, funct 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-019 States: FETCH, DCD, EXE, ALU_WB, MA, MRD, MEM_WB, MST, BR, JMP.
REQ-020 FETCH: irwr=1, pcwr=1, npcop=00; next state is DCD.
REQ-021 DCD: no enable is asserted.
REQ-022 DCD next state by instruction: R-type ALU and ori/lui go to EXE; lw/sw go to MA; beq goes to BR; j/jal/jr go to JMP.
REQ-023 Unsupported op/funct SHALL return from DCD to FETCH with no write enable asserted.
REQ-024 EXE: R-type drives bsel=0 with aluop add or sub; ori drives bsel=1, extop=00, aluop=10; lui drives bsel=1, extop=10, aluop=10. Next state is ALU_WB.
REQ-025 ALU_WB: regwr=1, wdsel=00, regdst=01 for R-type and 00 for I-type; next state is FETCH.
REQ-026 MA: bsel=1, extop=01, aluop=00; next state is MRD for lw, MST for sw.
REQ-027 MRD: next state is MEM_WB.
REQ-028 MEM_WB: regwr=1, wdsel=01, regdst=00; next state is FETCH.
REQ-029 MST: dmwr=1; next state is FETCH.
REQ-030 BR: aluop=01, npcop=01, pcwr=zero (Mealy, same cycle); next state is FETCH.
REQ-031 JMP: pcwr=1 with npcop=10 for j/jal and 11 for jr.
REQ-032 jal additionally asserts regwr=1, regdst=10, wdsel=10 in JMP; next state is FETCH.
REQ-033 CPI: branch/jump 3; R-type, I-ALU and sw 4; lw 5; illegal 2.
REQ-034 All outputs not named for a state SHALL be 0.
REQ-035 At most one of irwr, regwr, dmwr SHALL be high in any cycle, except none.
REQ-036 op/funct SHALL be sampled only in DCD and later states; the IR is stable because irwr is high only in FETCH.

Reset
REQ-037 While rst=1, state SHALL load FETCH and every enable output (irwr, pcwr, regwr, dmwr) SHALL be forced to 0.
REQ-038 While rst=1, all select outputs SHALL be 0.
REQ-039 Reset asserted in any state, including mid-lw, SHALL abort the instruction with no further write.
REQ-040 The first cycle after rst falls SHALL be FETCH with irwr=1.

Structure
REQ-041 Shared package mc_pkg SHALL hold: state enum; opcode/funct constants; npcop, regdst, wdsel, extop and aluop encodings.
REQ-042 Sub-module mc_decode SHALL map op/funct to an instruction-class one-hot (rtype_alu, ialu, load, store, branch, jump, link, jreg, illegal).
REQ-043 multi_ctrl SHALL hold only the state register and the output/next-state logic.

Verification
REQ-044 Reset mid-MRD, then release -> no regwr; next cycle FETCH with irwr=1, pcwr=1.
REQ-045 addu then lw -> 4 then 5 cycles; regwr high only in ALU_WB (regdst=01) and MEM_WB (wdsel=01).
REQ-046 beq in BR: zero=1 -> pcwr=1, npcop=01; zero=0 -> pcwr=0; both take 3 cycles.
REQ-047 jal -> JMP cycle with pcwr=1, npcop=10, regwr=1, regdst=10, wdsel=10.
REQ-048 op=111111 -> FETCH, DCD, FETCH with no pcwr/regwr/dmwr outside FETCH.
REQ-049 Random legal instruction stream -> irwr pulses exactly once per instruction, and one-of-irwr/regwr/dmwr holds every cycle.
